// File: rtl/exe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exe_sequencer
// Purpose  : Instruction sequencer. Fetches 5-bit instruction words from a
//            memory with one cycle of read latency, decodes them and fires a
//            single start strobe into one of the execution units, then waits
//            for that unit's completion pulse before fetching the next word.
//            Opcode 111 stops the program; opcode 101 is a NOP.
// Ports    : clk           - clock, all state changes on the rising edge
//            reset         - asynchronous, active-low
//            start         - launch program at address 0 (IDLE or HALT only)
//            instr_addr    - program counter / instruction memory address
//            instr_rd      - instruction read strobe (FETCH)
//            instr_data    - [4:2] opcode, [1] read_from, [0] write_to_reg
//            unit_done     - completion pulse from the active unit
//            add_en .. write_to_mem - one-cycle unit start strobes
//            add_or_sub    - 0 = add, 1 = subtract
//            read_from     - operand source select
//            write_to_reg  - writeback control
//            busy          - program running
//            halted        - stop opcode reached (or unit timeout)
//            error         - unit timeout occurred
// Option   : EXE_TIMEOUT_EN - when defined, a WAIT lasting TIMEOUT_CYCLES
//            cycles without unit_done halts the program with error=1.
// Revision : 1.0 - initial release
// ============================================================================
module exe_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_rd,
  input  logic [4:0]        instr_data,
  input  logic              unit_done,
  output logic              add_en,
  output logic              scale_en,
  output logic              mult_en,
  output logic              transpose_en,
  output logic              write_to_mem,
  output logic              add_or_sub,
  output logic              read_from,
  output logic              write_to_reg,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SCALE = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_TRANS = 3'b100;
  localparam logic [2:0] OP_NOP   = 3'b101;
  localparam logic [2:0] OP_WMEM  = 3'b110;
  localparam logic [2:0] OP_STOP  = 3'b111;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [4:0]        ir;
  logic [2:0]        ir_op;

  assign ir_op      = ir[4:2];
  assign instr_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Read data arrives during DECODE (one cycle after the FETCH strobe).
      if (state == ST_DECODE) begin
        ir <= instr_data;
      end
    end
  end

`ifdef EXE_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1; it is reloaded in EXEC.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             timeout_hit;

  // unit_done on the last allowed cycle wins over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !unit_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_EXEC) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if ((state == ST_HALT) && start) begin
        err_q <= 1'b0;
      end
    end
  end

  assign error = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign error = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_rd     = 1'b0;
    add_en       = 1'b0;
    scale_en     = 1'b0;
    mult_en      = 1'b0;
    transpose_en = 1'b0;
    write_to_mem = 1'b0;
    add_or_sub   = 1'b0;
    read_from    = 1'b0;
    write_to_reg = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        busy      = 1'b1;
        instr_rd  = 1'b1;
        state_nxt = ST_DECODE;
      end

      // Branch on the live read data; the IR captures it on this same edge.
      ST_DECODE: begin
        busy = 1'b1;
        case (instr_data[4:2])
          OP_STOP: state_nxt = ST_HALT;
          OP_NOP: begin
            pc_nxt    = pc + 1'b1;
            state_nxt = ST_FETCH;
          end
          default: state_nxt = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        busy         = 1'b1;
        add_or_sub   = (ir_op == OP_SUB);
        read_from    = ir[1];
        write_to_reg = ir[0];
        case (ir_op)
          OP_ADD, OP_SUB: add_en       = 1'b1;
          OP_SCALE:       scale_en     = 1'b1;
          OP_MULT:        mult_en      = 1'b1;
          OP_TRANS:       transpose_en = 1'b1;
          OP_WMEM:        write_to_mem = 1'b1;
          default:        ;
        endcase
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        busy         = 1'b1;
        add_or_sub   = (ir_op == OP_SUB);
        read_from    = ir[1];
        write_to_reg = ir[0];
        if (unit_done) begin
          pc_nxt    = pc + 1'b1;
          state_nxt = ST_FETCH;
        end
`ifdef EXE_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nxt = ST_HALT;
        end
`endif
      end

      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_nxt    = '0;
          state_nxt = ST_FETCH;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
